// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - framebuffer VGA scanout peripheral; VGA_TEST_PATTERN_EN enables colour-bar test pattern
module vga_fb_scanout #(
  parameter logic [31:0] BASE_ADDR = 32'hD0000000,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int SCALE      = 1,
  parameter int PIX_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic        ahb_clk,
  input  logic        n_rst,
  input  logic        wen,
  input  logic        ren,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        request_stall,
  output logic        error,
  output logic        vga_clk,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        frame_irq
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam int FB_PIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int DEPTH    = FB_PIX / 4;
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SSH      = $clog2(SCALE);
  localparam int WIN_W    = IMG_WIDTH * SCALE;
  localparam int WIN_H    = IMG_HEIGHT * SCALE;
  localparam int XS       = (H_ACTIVE - WIN_W) / 2;
  localparam int YS       = (V_ACTIVE - WIN_H) / 2;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [31:0] OFF_CTRL   = 32'h0001_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0001_0004;
  localparam logic [31:0] OFF_BG     = 32'h0001_0008;

  // ---------------- pixel clock enable ----------------
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic          pix_en;

  assign pix_en   = (div_cnt == DW'(PIX_DIV - 1));
  assign div_next = pix_en ? '0 : div_cnt + DW'(1);

  // Divider and DAC clock; vga_clk is registered from the next count so it tracks div_cnt exactly
  always_ff @(posedge ahb_clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt <= '0;
      vga_clk <= 1'b0;
    end else begin
      div_cnt <= div_next;
      vga_clk <= (int'(div_next) >= PIX_DIV / 2);
    end
  end

  // ---------------- raster counters (S0) ----------------
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  // Horizontal/vertical position, advancing one pixel per pix_en
  always_ff @(posedge ahb_clk or negedge n_rst) begin
    if (!n_rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h == HW'(H_TOTAL - 1)) begin
        h <= '0;
        v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
    end
  end

  // ---------------- registers ----------------
  logic [2:0]  ctrl;
  logic [23:0] bgcolor;
  logic [15:0] frame_count;
  logic        in_vblank;

  assign in_vblank = (int'(v) >= V_ACTIVE);

  // ---------------- S0 decode: window mapping and sync ranges ----------------
  int      dx;
  int      dy;
  int      idx;
  logic    s0_win;
  logic    s0_active;
  logic    s0_hsync;
  logic    s0_vsync;
  logic [AW-1:0] s0_word;
  logic [1:0]    s0_lane;

  // Map the screen position into the framebuffer and classify the pixel
  always_comb begin
    dx        = int'(h) - XS;
    dy        = int'(v) - YS;
    s0_win    = (dx >= 0) && (dx < WIN_W) && (dy >= 0) && (dy < WIN_H);
    idx       = s0_win ? ((dy >>> SSH) * IMG_WIDTH + (dx >>> SSH)) : 0;
    s0_word   = AW'(idx >>> 2);
    s0_lane   = idx[1:0];
    s0_active = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    s0_hsync  = (int'(h) >= HS_START) && (int'(h) < HS_END);
    s0_vsync  = (int'(v) >= VS_START) && (int'(v) < VS_END);
  end

  // ---------------- bus front end ----------------
  logic [31:0]   off;
  logic          a_fb;
  logic [AW-1:0] a_word;
  logic          busy;
  logic          b_write;
  logic [31:0]   b_off;
  logic [31:0]   b_wdata;
  logic          b_fb;
  logic          b_ctrl;
  logic          b_stat;
  logic          b_bg;
  logic          b_mapped;

  assign off      = addr - BASE_ADDR;
  assign a_fb     = (off < 32'(FB_PIX));
  assign a_word   = a_fb ? off[AW+1:2] : '0;
  assign b_fb     = (b_off < 32'(FB_PIX));
  assign b_ctrl   = (b_off == OFF_CTRL);
  assign b_stat   = (b_off == OFF_STATUS);
  assign b_bg     = (b_off == OFF_BG);
  assign b_mapped = b_fb | b_ctrl | b_stat | b_bg;

  assign request_stall = (wen | ren) & ~busy;
  assign error         = busy & ~b_mapped;

  // Two-cycle access: capture request in cycle 1, complete in cycle 2
  always_ff @(posedge ahb_clk or negedge n_rst) begin
    if (!n_rst) begin
      busy    <= 1'b0;
      b_write <= 1'b0;
      b_off   <= '0;
      b_wdata <= '0;
    end else if (busy) begin
      busy <= 1'b0;
    end else if (wen | ren) begin
      busy    <= 1'b1;
      b_write <= wen;
      b_off   <= off;
      b_wdata <= wdata;
    end
  end

  // ---------------- framebuffer RAM ----------------
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] qa;
  logic [31:0] qb;
  logic [AW-1:0] b_word;

  assign b_word = b_fb ? b_off[AW+1:2] : '0;

  // Port A: bus read issued in cycle 1, write committed in cycle 2; port B: scanout (S1)
  always_ff @(posedge ahb_clk) begin
    if (busy && b_write && b_fb) begin
      mem[b_word] <= b_wdata;
    end
    qa <= mem[a_word];
    if (pix_en) begin
      qb <= mem[s0_word];
    end
  end

  // Register file writes; bit2 of CTRL only exists with the test pattern built in
  always_ff @(posedge ahb_clk or negedge n_rst) begin
    if (!n_rst) begin
      ctrl    <= 3'd0;
      bgcolor <= 24'd0;
    end else if (busy && b_write) begin
      if (b_ctrl) begin
`ifdef VGA_TEST_PATTERN_EN
        ctrl <= b_wdata[2:0];
`else
        ctrl <= {1'b0, b_wdata[1:0]};
`endif
      end
      if (b_bg) begin
        bgcolor <= b_wdata[23:0];
      end
    end
  end

  // Read data only during the completing read cycle
  always_comb begin
    rdata = 32'd0;
    if (busy && !b_write) begin
      if (b_fb)        rdata = qa;
      else if (b_ctrl) rdata = {29'd0, ctrl};
      else if (b_stat) rdata = {frame_count, 15'd0, in_vblank};
      else if (b_bg)   rdata = {8'd0, bgcolor};
    end
  end

  // Frame interrupt and counter at the pixel tick that starts vsync
  always_ff @(posedge ahb_clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_irq   <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      frame_irq <= 1'b0;
      if (pix_en && (h == '0) && (v == VW'(VS_START))) begin
        frame_irq   <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // ---------------- S1 pipeline registers ----------------
  logic       s1_win;
  logic       s1_active;
  logic       s1_hsync;
  logic       s1_vsync;
  logic [1:0] s1_lane;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] s1_bar;
  logic [2:0] s0_bar;
  assign s0_bar = ((int'(h) / (H_ACTIVE / 8)) > 7) ? 3'd7 : 3'(int'(h) / (H_ACTIVE / 8));
`endif

  // Carry pixel attributes alongside the RAM read so they line up with qb
  always_ff @(posedge ahb_clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_win    <= 1'b0;
      s1_active <= 1'b0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_lane   <= 2'd0;
`ifdef VGA_TEST_PATTERN_EN
      s1_bar    <= 3'd0;
`endif
    end else if (pix_en) begin
      s1_win    <= s0_win;
      s1_active <= s0_active;
      s1_hsync  <= s0_hsync;
      s1_vsync  <= s0_vsync;
      s1_lane   <= s0_lane;
`ifdef VGA_TEST_PATTERN_EN
      s1_bar    <= s0_bar;
`endif
    end
  end

  // ---------------- S2 lane select and format expansion ----------------
  logic [7:0]  pix;
  logic [23:0] fb_rgb;
  logic [23:0] rgb_next;

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction
`endif

  // Choose framebuffer, background or blank colour for the pixel in S1
  always_comb begin
    pix = 8'd0;
    case (s1_lane)
      2'd0: pix = qb[7:0];
      2'd1: pix = qb[15:8];
      2'd2: pix = qb[23:16];
      2'd3: pix = qb[31:24];
      default: pix = 8'd0;
    endcase
    if (ctrl[1]) begin
      fb_rgb = {pix[7:5], pix[7:5], pix[7:6],
                pix[4:2], pix[4:2], pix[4:3],
                {4{pix[1:0]}}};
    end else begin
      fb_rgb = {pix, pix, pix};
    end
    rgb_next = 24'd0;
    if (s1_active && ctrl[0]) begin
      if (s1_win) rgb_next = fb_rgb;
      else        rgb_next = bgcolor;
`ifdef VGA_TEST_PATTERN_EN
      if (ctrl[2]) rgb_next = bar_colour(s1_bar);
`endif
    end
  end

  // ---------------- S3 output registers ----------------
  // Output stage; syncs run regardless of enable
  always_ff @(posedge ahb_clk or negedge n_rst) begin
    if (!n_rst) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'd0;
      vga_g       <= 8'd0;
      vga_b       <= 8'd0;
    end else if (pix_en) begin
      vga_hs      <= ~s1_hsync;
      vga_vs      <= ~s1_vsync;
      vga_blank_n <= s1_active;
      vga_r       <= rgb_next[23:16];
      vga_g       <= rgb_next[15:8];
      vga_b       <= rgb_next[7:0];
    end
  end

  assign vga_sync_n = 1'b0;

endmodule
